// File: rtl/snn_config_loader.sv
// snn_config_loader: byte-command configuration loader for the spiking network.
// It decodes framed SPI bytes into WRITE, READ, COMMIT and CLEAR commands.
// Writes land in a shadow image. A COMMIT copies that image into the live
// cfg_active bus in a single edge. Bytes 0..SPIKE_BYTES-1 are a fast path:
// writes to them reach both images at once and raise spike_update.
// Optional feature macro: SNN_CFG_READBACK_EN enables the READ (0xB0)
// opcode and drives tx_data/tx_load. Without it, 0xB0 is an unknown opcode
// and the readback outputs are tied off.
module snn_config_loader #(
    parameter int CFG_BYTES   = 215,
    parameter int SPIKE_BYTES = 3,
    parameter int ADDR_W      = 8
) (
    input  logic                     system_clock,
    input  logic                     reset,
    input  logic                     frame_start,
    input  logic                     frame_end,
    input  logic                     byte_valid,
    input  logic [7:0]               byte_data,
    output logic [8*CFG_BYTES-1:0]   cfg_active,
    output logic                     spike_update,
    output logic                     commit_pulse,
    output logic                     err_oob,
    output logic                     err_opcode,
    output logic [7:0]               tx_data,
    output logic                     tx_load
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_OPC   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_LEN   = 3'd3,
        ST_WDATA = 3'd4,
        ST_RDATA = 3'd5,
        ST_SKIP  = 3'd6
    } state_e;

    localparam logic [7:0]      OP_WRITE  = 8'hA0;
    localparam logic [7:0]      OP_COMMIT = 8'hC0;
    localparam logic [7:0]      OP_CLEAR  = 8'hE0;
    localparam logic [ADDR_W:0] CFG_LIM   = (ADDR_W+1)'(CFG_BYTES);
    localparam logic [ADDR_W:0] SPIKE_LIM = (ADDR_W+1)'(SPIKE_BYTES);

    state_e              state_q, state_d, nxt_s, cur_state_s;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [7:0]          rem_q, rem_d;
    logic                rd_mode_q, rd_mode_d;
    logic                err_oob_q, err_oob_d;
    logic                err_opc_q, err_opc_d;
    logic                spike_q, spike_d;
    logic                commit_q, commit_d;
    logic                shadow_we_s, active_we_s, commit_s;
    logic                oob_s, in_spike_s;

    // The spike region is always written to both images and is never
    // overwritten by a commit. Its shadow copy would therefore always equal
    // active. Only the non-spike part of the shadow image is stored.
    logic [8*CFG_BYTES-1:8*SPIKE_BYTES] shadow_q;
    logic [8*CFG_BYTES-1:0]             active_q;

`ifdef SNN_CFG_READBACK_EN
    localparam logic [7:0] OP_READ = 8'hB0;
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_load_q, tx_load_d;
    logic [7:0] rd_byte_s;

    // Readback mux: the spike region reads from active, the rest from shadow
    always_comb begin
        rd_byte_s = 8'h00;
        for (int k = 0; k < SPIKE_BYTES; k++) begin
            rd_byte_s = (ptr_q == ADDR_W'(k)) ? active_q[8*k +: 8] : rd_byte_s;
        end
        for (int k = SPIKE_BYTES; k < CFG_BYTES; k++) begin
            rd_byte_s = (ptr_q == ADDR_W'(k)) ? shadow_q[8*k +: 8] : rd_byte_s;
        end
    end
`endif

    assign oob_s      = ({1'b0, ptr_q} >= CFG_LIM);
    assign in_spike_s = ({1'b0, ptr_q} < SPIKE_LIM);

    // Command decoder: next state, pointer/count updates, flags and write strobes
    always_comb begin
        cur_state_s = frame_start ? ST_OPC : state_q;
        nxt_s       = cur_state_s;
        ptr_d       = ptr_q;
        rem_d       = rem_q;
        rd_mode_d   = rd_mode_q;
        err_oob_d   = err_oob_q;
        err_opc_d   = err_opc_q;
        spike_d     = 1'b0;
        commit_d    = 1'b0;
        shadow_we_s = 1'b0;
        active_we_s = 1'b0;
        commit_s    = 1'b0;
`ifdef SNN_CFG_READBACK_EN
        tx_data_d   = tx_data_q;
        tx_load_d   = 1'b0;
`endif
        if (byte_valid) begin
            case (cur_state_s)
                ST_OPC: begin
                    case (byte_data)
                        OP_WRITE: begin
                            rd_mode_d = 1'b0;
                            nxt_s     = ST_ADDR;
                        end
`ifdef SNN_CFG_READBACK_EN
                        OP_READ: begin
                            rd_mode_d = 1'b1;
                            nxt_s     = ST_ADDR;
                        end
`endif
                        OP_COMMIT: begin
                            commit_s = 1'b1;
                            commit_d = 1'b1;
                            nxt_s    = ST_SKIP;
                        end
                        OP_CLEAR: begin
                            err_oob_d = 1'b0;
                            err_opc_d = 1'b0;
                            nxt_s     = ST_SKIP;
                        end
                        default: begin
                            err_opc_d = 1'b1;
                            nxt_s     = ST_SKIP;
                        end
                    endcase
                end
                ST_ADDR: begin
                    ptr_d = ADDR_W'(byte_data);
                    nxt_s = rd_mode_q ? ST_RDATA : ST_LEN;
                end
                ST_LEN: begin
                    rem_d = byte_data;
                    nxt_s = (byte_data == 8'h00) ? ST_SKIP : ST_WDATA;
                end
                ST_WDATA: begin
                    if (oob_s) begin
                        err_oob_d = 1'b1;
                    end else if (in_spike_s) begin
                        active_we_s = 1'b1;
                        spike_d     = 1'b1;
                    end else begin
                        shadow_we_s = 1'b1;
                    end
                    ptr_d = ptr_q + ADDR_W'(1);
                    rem_d = rem_q - 8'd1;
                    nxt_s = (rem_q == 8'd1) ? ST_SKIP : ST_WDATA;
                end
                ST_RDATA: begin
`ifdef SNN_CFG_READBACK_EN
                    if (oob_s) begin
                        tx_data_d = 8'h00;
                        err_oob_d = 1'b1;
                    end else begin
                        tx_data_d = rd_byte_s;
                    end
                    tx_load_d = 1'b1;
                    ptr_d     = ptr_q + ADDR_W'(1);
`else
                    nxt_s     = ST_SKIP;
`endif
                end
                default: nxt_s = cur_state_s;
            endcase
        end else begin
            nxt_s = cur_state_s;
        end
        state_d = frame_end ? ST_IDLE : nxt_s;
    end

    // Control registers: FSM state, pointer, count, sticky flags, pulses
    always_ff @(posedge system_clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            rem_q     <= 8'h00;
            rd_mode_q <= 1'b0;
            err_oob_q <= 1'b0;
            err_opc_q <= 1'b0;
            spike_q   <= 1'b0;
            commit_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            rem_q     <= rem_d;
            rd_mode_q <= rd_mode_d;
            err_oob_q <= err_oob_d;
            err_opc_q <= err_opc_d;
            spike_q   <= spike_d;
            commit_q  <= commit_d;
        end
    end

`ifdef SNN_CFG_READBACK_EN
    // Readback output registers
    always_ff @(posedge system_clock or negedge reset) begin
        if (!reset) begin
            tx_data_q <= 8'h00;
            tx_load_q <= 1'b0;
        end else begin
            tx_data_q <= tx_data_d;
            tx_load_q <= tx_load_d;
        end
    end
`endif

    // Shadow image: byte writes outside the spike region
    always_ff @(posedge system_clock or negedge reset) begin
        if (!reset) begin
            shadow_q <= '0;
        end else begin
            for (int k = SPIKE_BYTES; k < CFG_BYTES; k++) begin
                if (shadow_we_s && (ptr_q == ADDR_W'(k))) begin
                    shadow_q[8*k +: 8] <= byte_data;
                end
            end
        end
    end

    // Active image: fast-path spike writes plus the atomic commit of the rest
    always_ff @(posedge system_clock or negedge reset) begin
        if (!reset) begin
            active_q <= '0;
        end else begin
            for (int k = 0; k < SPIKE_BYTES; k++) begin
                if (active_we_s && (ptr_q == ADDR_W'(k))) begin
                    active_q[8*k +: 8] <= byte_data;
                end
            end
            for (int k = SPIKE_BYTES; k < CFG_BYTES; k++) begin
                if (commit_s) begin
                    active_q[8*k +: 8] <= shadow_q[8*k +: 8];
                end
            end
        end
    end

    assign cfg_active   = active_q;
    assign spike_update = spike_q;
    assign commit_pulse = commit_q;
    assign err_oob      = err_oob_q;
    assign err_opcode   = err_opc_q;
`ifdef SNN_CFG_READBACK_EN
    assign tx_data      = tx_data_q;
    assign tx_load      = tx_load_q;
`else
    assign tx_data      = 8'h00;
    assign tx_load      = 1'b0;
`endif

endmodule

// File: tb/tb_snn_config_loader.sv
// Self-checking bench for snn_config_loader. It plays framed byte commands,
// some directed and some random. A frame-level reference model interprets
// each byte from its position in the frame.
module tb_snn_config_loader;

    localparam int CFG = 215;
    localparam int SPK = 3;
    localparam int AW  = 8;
`ifdef SNN_CFG_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             frame_start, frame_end, byte_valid;
    logic [7:0]       byte_data;
    logic [8*CFG-1:0] cfg_active;
    logic             spike_update, commit_pulse, err_oob, err_opcode;
    logic [7:0]       tx_data;
    logic             tx_load;

    always #5 clk = ~clk;

    snn_config_loader #(.CFG_BYTES(CFG), .SPIKE_BYTES(SPK), .ADDR_W(AW)) dut (
        .system_clock (clk),
        .reset        (rst_n),
        .frame_start  (frame_start),
        .frame_end    (frame_end),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .cfg_active   (cfg_active),
        .spike_update (spike_update),
        .commit_pulse (commit_pulse),
        .err_oob      (err_oob),
        .err_opcode   (err_opcode),
        .tx_data      (tx_data),
        .tx_load      (tx_load)
    );

    int         n_total = 0;
    int         n_bad   = 0;
    logic [7:0] m_shadow [CFG];
    logic [7:0] m_active [CFG];
    logic       m_oob, m_opc;
    logic [7:0] m_txd;
    logic [7:0] fq [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < CFG; k++) begin
            m_shadow[k] = 8'h00;
            m_active[k] = 8'h00;
        end
        m_oob = 1'b0;
        m_opc = 1'b0;
        m_txd = 8'h00;
    endtask

    // Interpret byte i of the frame held in fq; update the model; return pulses expected
    task automatic model_byte(input int i, output bit e_sp, output bit e_cm, output bit e_tl);
        logic [7:0] op;
        logic [7:0] b;
        int a;
        op = fq[0];
        b  = fq[i];
        e_sp = 1'b0; e_cm = 1'b0; e_tl = 1'b0;
        if (i == 0) begin
            if (b == 8'hA0 || (RB && b == 8'hB0)) begin
                e_sp = 1'b0;
            end else if (b == 8'hC0) begin
                for (int k = SPK; k < CFG; k++) m_active[k] = m_shadow[k];
                e_cm = 1'b1;
            end else if (b == 8'hE0) begin
                m_oob = 1'b0;
                m_opc = 1'b0;
            end else begin
                m_opc = 1'b1;
            end
        end else if (op == 8'hA0) begin
            if (i >= 3 && (i - 3) < int'(fq[2])) begin
                a = (int'(fq[1]) + i - 3) % (1 << AW);
                if (a >= CFG) begin
                    m_oob = 1'b1;
                end else begin
                    m_shadow[a] = b;
                    if (a < SPK) begin
                        m_active[a] = b;
                        e_sp = 1'b1;
                    end
                end
            end
        end else if (RB && op == 8'hB0) begin
            if (i >= 2) begin
                a = (int'(fq[1]) + i - 2) % (1 << AW);
                e_tl = 1'b1;
                if (a < CFG) begin
                    m_txd = m_shadow[a];
                end else begin
                    m_txd = 8'h00;
                    m_oob = 1'b1;
                end
            end
        end
    endtask

    task automatic check_outputs(input bit e_sp, input bit e_cm, input bit e_tl, input string w);
        int d;
        d = 0;
        chk({w, ".spike_update"}, 32'(spike_update), 32'(e_sp));
        chk({w, ".commit_pulse"}, 32'(commit_pulse), 32'(e_cm));
        chk({w, ".tx_load"},      32'(tx_load),      32'(e_tl));
        chk({w, ".tx_data"},      32'(tx_data),      32'(m_txd));
        chk({w, ".err_oob"},      32'(err_oob),      32'(m_oob));
        chk({w, ".err_opcode"},   32'(err_opcode),   32'(m_opc));
        for (int k = 0; k < CFG; k++) begin
            if (cfg_active[8*k +: 8] !== m_active[k]) begin
                d = k;
                break;
            end
        end
        chk($sformatf("%s.active[%0d]", w, d), 32'(cfg_active[8*d +: 8]), 32'(m_active[d]));
    endtask

    task automatic cycle(input logic fs, input logic fe, input logic bv, input logic [7:0] bd);
        @(negedge clk);
        frame_start = fs;
        frame_end   = fe;
        byte_valid  = bv;
        byte_data   = bd;
        @(posedge clk);
        #1;
    endtask

    // Drive the frame in fq; sep_s/sep_e put frame_start/frame_end on their own cycles
    task automatic send_frame(input bit sep_s, input bit sep_e, input string nm);
        int n;
        bit sp, cm, tl;
        n = fq.size();
        if (sep_s) begin
            cycle(1'b1, 1'b0, 1'b0, 8'h00);
            check_outputs(1'b0, 1'b0, 1'b0, {nm, ".fs"});
        end
        for (int i = 0; i < n; i++) begin
            cycle((i == 0) && !sep_s, (i == n - 1) && !sep_e, 1'b1, fq[i]);
            model_byte(i, sp, cm, tl);
            check_outputs(sp, cm, tl, $sformatf("%s.b%0d", nm, i));
        end
        if (sep_e) begin
            cycle(1'b0, 1'b1, 1'b0, 8'h00);
            check_outputs(1'b0, 1'b0, 1'b0, {nm, ".fe"});
        end
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        check_outputs(1'b0, 1'b0, 1'b0, {nm, ".gap"});
    endtask

    task automatic pulse_reset(input string nm);
        @(negedge clk);
        rst_n       = 1'b0;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        byte_valid  = 1'b0;
        #1;
        model_reset();
        check_outputs(1'b0, 1'b0, 1'b0, nm);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic random_frame();
        int r;
        int nd;
        logic [7:0] addr;
        fq.delete();
        r = $urandom_range(0, 9);
        case ($urandom_range(0, 2))
            0:       addr = 8'($urandom_range(0, 5));
            1:       addr = 8'($urandom_range(208, 255));
            default: addr = 8'($urandom_range(0, 255));
        endcase
        if (r <= 3) begin
            fq.push_back(8'hA0);
            fq.push_back(addr);
            fq.push_back(8'($urandom_range(0, 6)));
            nd = $urandom_range(0, int'(fq[2]) + 2);
            for (int j = 0; j < nd; j++) fq.push_back(8'($urandom_range(0, 255)));
        end else if (r <= 5) begin
            fq.push_back(8'hB0);
            fq.push_back(addr);
            nd = $urandom_range(0, 4);
            for (int j = 0; j < nd; j++) fq.push_back(8'($urandom_range(0, 255)));
        end else begin
            case (r)
                6:       fq.push_back(8'hC0);
                7:       fq.push_back(8'hE0);
                default: fq.push_back(8'($urandom_range(0, 255)));
            endcase
            nd = $urandom_range(0, 3);
            for (int j = 0; j < nd; j++) fq.push_back(8'($urandom_range(0, 255)));
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        byte_valid  = 1'b0;
        byte_data   = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs(1'b0, 1'b0, 1'b0, "por");
        @(negedge clk);
        rst_n = 1'b1;

        fq = '{8'hA0, 8'h05, 8'h02, 8'h3C, 8'h7E};  send_frame(1'b0, 1'b0, "wr5");
        fq = '{8'hC0};                               send_frame(1'b1, 1'b1, "commit5");
        fq = '{8'hA0, 8'h01, 8'h01, 8'hFF};          send_frame(1'b0, 1'b1, "spike1");
        fq = '{8'hA0, 8'hD6, 8'h02, 8'h11, 8'h22};   send_frame(1'b1, 1'b0, "wr_end");
        fq = '{8'hC0};                               send_frame(1'b0, 1'b0, "commit_end");
        fq = '{8'hE0};                               send_frame(1'b0, 1'b0, "clear");
        fq = '{8'h55, 8'hA0, 8'h00, 8'h01, 8'h99};   send_frame(1'b0, 1'b0, "badop");
        fq = '{8'hB0, 8'h05, 8'h00, 8'h00};          send_frame(1'b0, 1'b0, "read5");
        fq = '{8'hE0};                               send_frame(1'b1, 1'b0, "clear2");
        fq = '{8'hA0, 8'h10, 8'h04, 8'hAA, 8'hBB};   send_frame(1'b0, 1'b0, "abort");
        fq = '{8'hC0};                               send_frame(1'b0, 1'b0, "commit_abort");
        fq = '{8'hA0, 8'h20};
        cycle(1'b1, 1'b0, 1'b1, 8'hA0);
        cycle(1'b0, 1'b0, 1'b1, 8'h20);
        pulse_reset("rst_mid");
        // Bytes without frame_start after reset must be ignored
        cycle(1'b0, 1'b0, 1'b1, 8'hE0);
        check_outputs(1'b0, 1'b0, 1'b0, "idle_byte0");
        cycle(1'b0, 1'b0, 1'b1, 8'h02);
        check_outputs(1'b0, 1'b0, 1'b0, "idle_byte1");

        for (int f = 0; f < 80; f++) begin
            random_frame();
            send_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", f));
            if ($urandom_range(0, 5) == 0) begin
                cycle(1'b0, 1'b0, 1'b1, 8'($urandom_range(0, 255)));
                check_outputs(1'b0, 1'b0, 1'b0, $sformatf("stray%0d", f));
            end
            if ($urandom_range(0, 24) == 0) pulse_reset($sformatf("rst%0d", f));
        end
        fq = '{8'hC0};
        send_frame(1'b0, 1'b0, "final_commit");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
